// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU result stream, load-return stream and register file write port.
// Forwarding signals exist only when WB_BYPASS_EN is defined.
interface wb_arbiter_if #(
  parameter int DEPTH = 4
);
  logic                     alu_valid;
  logic [4:0]               alu_rd;
  logic [31:0]              alu_data;
  logic                     stall;
  logic                     ld_valid;
  logic                     ld_ready;
  logic [4:0]               ld_rd;
  logic [2:0]               ld_funct3;
  logic [1:0]               ld_offset;
  logic [31:0]              ld_word;
  logic                     reg_we;
  logic [4:0]               rd;
  logic [31:0]              rd_value;
  logic [$clog2(DEPTH):0]   fifo_count;
`ifdef WB_BYPASS_EN
  logic [4:0]               ra;
  logic [4:0]               rb;
  logic                     fwd_a_hit;
  logic                     fwd_b_hit;
  logic [31:0]              fwd_value;
`endif

  // Arbiter side
  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_funct3, ld_offset, ld_word,
`ifdef WB_BYPASS_EN
    input  ra, rb,
    output fwd_a_hit, fwd_b_hit, fwd_value,
`endif
    output stall, ld_ready, reg_we, rd, rd_value, fifo_count
  );

  // Producer / register file side
  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_funct3, ld_offset, ld_word,
`ifdef WB_BYPASS_EN
    output ra, rb,
    input  fwd_a_hit, fwd_b_hit, fwd_value,
`endif
    input  stall, ld_ready, reg_we, rd, rd_value, fifo_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results with FIFO-buffered load returns onto the regfile write port.
// Optional decode forwarding outputs are enabled with `define WB_BYPASS_EN.
module wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic           clk,
  input  logic           rst,
  wb_arbiter_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [1:0]  offset;
    logic [31:0] word;
  } ld_ent_t;

  ld_ent_t        mem [DEPTH];
  ld_ent_t        head;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic [SW-1:0]  starve;
  logic           empty, push, pop, alu_win;
  logic           reg_we;
  logic [4:0]     rd;
  logic [31:0]    rd_value;

  function automatic logic [31:0] fmt(input ld_ent_t e);
    logic [7:0]  b;
    logic [15:0] h;
    b = e.word[{e.offset, 3'b000} +: 8];
    h = e.offset[1] ? e.word[31:16] : e.word[15:0];
    case (e.funct3)
      3'b000:  fmt = {{24{b[7]}}, b};
      3'b100:  fmt = {24'h0, b};
      3'b001:  fmt = {{16{h[15]}}, h};
      3'b101:  fmt = {16'h0, h};
      default: fmt = e.word;
    endcase
  endfunction

  assign empty        = (count == '0);
  assign head         = mem[rd_ptr];
  assign bus.ld_ready = !rst && (count < CW'(DEPTH));
  assign bus.stall    = !rst && !empty && (starve == SW'(STARVE_MAX));
  // rd==0 loads are consumed by the handshake but never stored
  assign push         = bus.ld_valid && bus.ld_ready && (bus.ld_rd != 5'd0);

  always_comb begin
    pop     = 1'b0;
    alu_win = 1'b0;
    if (bus.stall && !empty)                       pop     = 1'b1;
    else if (bus.alu_valid && bus.alu_rd != 5'd0)  alu_win = 1'b1;
    else if (!empty)                               pop     = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{rd: bus.ld_rd, funct3: bus.ld_funct3,
                               offset: bus.ld_offset, word: bus.ld_word};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      starve   <= '0;
      reg_we   <= 1'b0;
      rd       <= '0;
      rd_value <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (pop || empty)                   starve <= '0;
      else if (starve != SW'(STARVE_MAX)) starve <= starve + 1'b1;
      reg_we <= pop || alu_win;
      if (pop) begin
        rd       <= head.rd;
        rd_value <= fmt(head);
      end else if (alu_win) begin
        rd       <= bus.alu_rd;
        rd_value <= bus.alu_data;
      end
    end
  end

  assign bus.reg_we     = reg_we;
  assign bus.rd         = rd;
  assign bus.rd_value   = rd_value;
  assign bus.fifo_count = count;

`ifdef WB_BYPASS_EN
  assign bus.fwd_a_hit = reg_we && (rd == bus.ra) && (bus.ra != 5'd0);
  assign bus.fwd_b_hit = reg_we && (rd == bus.rb) && (bus.rb != 5'd0);
  assign bus.fwd_value = rd_value;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: formatting, backpressure, starvation stall, rd=0 and reset flush.
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  wb_arbiter_if #(.DEPTH(4)) bus ();
  wb_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_alu(input logic v, input logic [4:0] r, input logic [31:0] d);
    bus.alu_valid = v; bus.alu_rd = r; bus.alu_data = d;
  endtask

  task automatic set_ld(input logic v, input logic [4:0] r, input logic [2:0] f3,
                        input logic [1:0] off, input logic [31:0] w);
    bus.ld_valid = v; bus.ld_rd = r; bus.ld_funct3 = f3; bus.ld_offset = off; bus.ld_word = w;
  endtask

  logic [2:0]  f3_t  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
  logic [1:0]  off_t [5] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd0};
  logic [31:0] exp_t [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h80FF0011};

  initial begin
`ifdef WB_BYPASS_EN
    bus.ra = '0; bus.rb = '0;
`endif
    set_alu(0, 0, 0);
    set_ld(0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("rst_ld_ready", 32'(bus.ld_ready), 0);
    chk("rst_stall", 32'(bus.stall), 0);
    tick(); tick();
    chk("rst_we", 32'(bus.reg_we), 0);
    chk("rst_rd", 32'(bus.rd), 0);
    chk("rst_value", bus.rd_value, 0);
    chk("rst_count", 32'(bus.fifo_count), 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(bus.ld_ready), 1);

    // ALU single write
    set_alu(1, 5, 32'h12345678);
    tick();
    set_alu(0, 0, 0);
    chk("alu_we", 32'(bus.reg_we), 1);
    chk("alu_rd", 32'(bus.rd), 5);
    chk("alu_value", bus.rd_value, 32'h12345678);
    tick();
    chk("alu_we_drop", 32'(bus.reg_we), 0);
    chk("alu_rd_hold", 32'(bus.rd), 5);

    // Load formatting, uncontended: written two cycles after acceptance
    for (int i = 0; i < 5; i++) begin
      set_ld(1, 7, f3_t[i], off_t[i], 32'h80FF0011);
      tick();
      set_ld(0, 0, 0, 0, 0);
      chk($sformatf("ld%0d_we_k1", i), 32'(bus.reg_we), 0);
      chk($sformatf("ld%0d_count", i), 32'(bus.fifo_count), 1);
      tick();
      chk($sformatf("ld%0d_we_k2", i), 32'(bus.reg_we), 1);
      chk($sformatf("ld%0d_rd", i), 32'(bus.rd), 7);
      chk($sformatf("ld%0d_value", i), bus.rd_value, exp_t[i]);
    end

    // Fill under constant ALU traffic, then starvation stall
    for (int c = 0; c <= 8; c++) begin
      set_alu(1, 3, 32'hA0000000 + c);
      if (c <= 4) set_ld(1, 5'(10 + c), 3'b010, 0, 32'h1000 + c);
      tick();
      if (c == 3) begin
        chk("full_count", 32'(bus.fifo_count), 4);
        chk("full_ready", 32'(bus.ld_ready), 0);
      end
      if (c == 7) chk("no_stall_c8", 32'(bus.stall), 0);
    end
    chk("stall_c9", 32'(bus.stall), 1);
    chk("alu_c8_rd", 32'(bus.rd), 3);
    chk("alu_c8_value", bus.rd_value, 32'hA0000008);
    set_alu(1, 3, 32'hA0000009);
    tick();
    chk("stall_pop_rd", 32'(bus.rd), 10);
    chk("stall_pop_value", bus.rd_value, 32'h1000);
    chk("stall_pop_count", 32'(bus.fifo_count), 3);
    chk("stall_cleared", 32'(bus.stall), 0);
    chk("ready_after_pop", 32'(bus.ld_ready), 1);
    tick();
    set_alu(0, 0, 0);
    set_ld(0, 0, 0, 0, 0);
    chk("replay_rd", 32'(bus.rd), 3);
    chk("replay_value", bus.rd_value, 32'hA0000009);
    chk("fifth_accepted", 32'(bus.fifo_count), 4);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("drain%0d_rd", i), 32'(bus.rd), 10 + i);
      chk($sformatf("drain%0d_value", i), bus.rd_value, 32'h1000 + i);
    end
    chk("drained_count", 32'(bus.fifo_count), 0);

    // rd=0 from both sources
    set_alu(1, 0, 32'hDEADBEEF);
    set_ld(1, 0, 3'b010, 0, 32'hCAFEF00D);
    tick();
    chk("rd0_we", 32'(bus.reg_we), 0);
    chk("rd0_count", 32'(bus.fifo_count), 0);
    set_alu(0, 0, 0);
    set_ld(1, 9, 3'b010, 0, 32'h55AA55AA);
    tick();
    set_ld(0, 0, 0, 0, 0);
    set_alu(1, 0, 32'hDEADBEEF);
    tick();
    set_alu(0, 0, 0);
    chk("rd0_slot_we", 32'(bus.reg_we), 1);
    chk("rd0_slot_rd", 32'(bus.rd), 9);
    chk("rd0_slot_value", bus.rd_value, 32'h55AA55AA);

    // Reset with three queued loads
    set_alu(1, 4, 32'h44444444);
    for (int i = 0; i < 3; i++) begin
      set_ld(1, 5'(20 + i), 3'b010, 0, 32'h2000 + i);
      tick();
    end
    chk("pre_rst_count", 32'(bus.fifo_count), 3);
    set_alu(0, 0, 0);
    set_ld(0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("in_rst_ready", 32'(bus.ld_ready), 0);
    chk("in_rst_stall", 32'(bus.stall), 0);
    tick();
    rst = 1'b0;
    chk("flush_count", 32'(bus.fifo_count), 0);
    chk("flush_we", 32'(bus.reg_we), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("flush_quiet%0d", i), 32'(bus.reg_we), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-stage arbiter and load-data formatter that drives the register file write port (write enable, rd index, rd value).
- Merges two producers:
  - a single-cycle ALU result stream that cannot be back-pressured, except via starvation stall;
  - a variable-latency load-return stream with valid/ready handshake.
- Load returns are buffered in a small FIFO. Sub-word extraction and sign/zero extension happen on dequeue.
- Sits between EX/MEM and the register file.

Parameters:
DEPTH, 4, load FIFO entries; power of two, ≥2
STARVE_MAX, 8, consecutive unserved cycles with FIFO non-empty before forcing a FIFO pop

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
alu_valid_i  in  1  ALU result valid this cycle
alu_rd_i  in  5  ALU destination register
alu_data_i  in  32  ALU result
stall_o  out  1  ALU input ignored this cycle; upstream re-presents the same result next cycle
ld_valid_i  in  1  load return valid
ld_ready_o  out  1  FIFO can accept a load return
ld_rd_i  in  5  load destination register
ld_funct3_i  in  3  load type (RV32I funct3)
ld_offset_i  in  2  byte offset, addr[1:0]
ld_word_i  in  32  raw aligned memory word
reg_we_o  out  1  register file write enable
rd_o  out  5  register file write index
rd_value_o  out  32  register file write data
fifo_count_o  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=1 at posedge):
  - FIFO emptied, count 0, starve counter 0.
  - reg_we_o=0, rd_o=0, rd_value_o=0.
  - Queued loads discarded.
  - ld_ready_o=0 and stall_o=0 while rst is high.
- Handshake:
  - ld_ready_o = (count < DEPTH), computed from the registered count.
  - Load accepted when ld_valid_i & ld_ready_o.
  - When full, no enqueue even if a pop occurs the same cycle.
  - Accepted load with ld_rd_i==0 is dropped; count is unchanged.
- Arbitration, evaluated each cycle; result is registered into the outputs at the next posedge:
  1. stall_o=1 and FIFO non-empty: pop head, write it; ALU input ignored.
  2. Else alu_valid_i & alu_rd_i!=0: write the ALU result.
  3. Else FIFO non-empty: pop head, write it.
  4. Else reg_we_o<=0; rd_o and rd_value_o hold.
- ALU result with rd=0 never writes and leaves the slot free for a FIFO pop.
- Latency:
  - ALU result in cycle k → reg_we_o high in cycle k+1.
  - Load accepted in cycle k with no contention → reg_we_o high in cycle k+2.
  - There is no same-cycle enqueue→pop path.
- Starvation:
  - Counter increments each cycle the FIFO is non-empty and no pop occurs; it saturates at STARVE_MAX.
  - Counter clears on any pop or when the FIFO is empty.
  - stall_o = (counter==STARVE_MAX) & FIFO non-empty, combinational.
- Load formatting on dequeue:
  - 000 LB: byte[offset], sign-extended.
  - 100 LBU: byte[offset], zero-extended.
  - 001 LH: half[offset[1]], sign-extended; offset[0] ignored.
  - 101 LHU: half[offset[1]], zero-extended.
  - 010 LW and all other codes: full word.
- Ordering:
  - FIFO is strictly in-order.
  - WAW ordering between ALU and load writes to the same rd is the upstream hazard unit's responsibility; writes occur in arbitration order.
- Pointers wrap modulo DEPTH; count distinguishes full from empty.
- Simultaneous enqueue and pop: count unchanged.

Optional Feature:
WB_BYPASS_EN
- Defined: adds inputs ra_i[4:0] and rb_i[4:0], and outputs fwd_a_hit_o, fwd_b_hit_o and fwd_value_o[31:0].
  - fwd_x_hit_o = reg_we_o & (rd_o==rx_i) & (rx_i!=0), combinational.
  - fwd_value_o = rd_value_o.
  - Decode uses these to bypass a write that has not yet landed in the register file.
- Undefined: these ports are absent; no forwarding logic.

Test Plan:
- ALU valid, rd=5, data 0x12345678 in cycle k → cycle k+1: reg_we_o=1, rd_o=5, rd_value_o=0x12345678.
- Loads to rd=7 with ld_word_i=0x80FF0011:
  - LB offset 3 → 0xFFFFFF80.
  - LBU offset 3 → 0x00000080.
  - LH offset 2 → 0xFFFF80FF.
  - LHU offset 2 → 0x000080FF.
  - LW → 0x80FF0011.
- ALU valid every cycle, rd≠0; present 5 loads → first 4 accepted, fifo_count_o=4, ld_ready_o=0 and 5th held.
- After 8 starved cycles (STARVE_MAX=8):
  - stall_o=1 in the 9th cycle and the head load is written next cycle.
  - The ALU result presented during stall is re-presented and written the cycle after.
- ALU rd=0 and load rd=0 accepted → reg_we_o stays 0 and fifo_count_o unchanged.
- 3 loads queued, rst pulsed 1 cycle → fifo_count_o=0, reg_we_o=0; no queued load is ever written.
